// File: rtl/fpu_cmd_sequencer.sv
// Command sequencer between the UART receiver and the half-precision FPU:
// builds 6-byte frames, issues them over valid/ready and latches the result.
module fpu_cmd_sequencer #(
    parameter logic [7:0]  HDR_BYTE     = 8'hA5,
    parameter logic [7:0]  NUM_OPS      = 8'd10,
    parameter logic [15:0] BYTE_TIMEOUT = 16'd50000,
    parameter logic [7:0]  FPU_TIMEOUT  = 8'd64
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        fpu_valid,
    input  logic        fpu_ready,
    output logic [3:0]  fpu_opcode,
    output logic [15:0] fpu_opa,
    output logic [15:0] fpu_opb,
    input  logic        fpu_done,
    input  logic [15:0] fpu_result,
    input  logic [4:0]  fpu_flags,
    output logic [15:0] result_o,
    output logic [4:0]  flags_o,
    output logic        result_valid,
    output logic        busy,
    output logic        err_o,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        OPC   = 3'd1,
        A_HI  = 3'd2,
        A_LO  = 3'd3,
        B_HI  = 3'd4,
        B_LO  = 3'd5,
        ISSUE = 3'd6,
        WAIT  = 3'd7
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BYTE_TO = 2'd1;
    localparam logic [1:0] ERR_ILL_OP  = 2'd2;
    localparam logic [1:0] ERR_FPU_TO  = 2'd3;

    state_t      state_reg,        state_next;
    logic [3:0]  opcode_reg,       opcode_next;
    logic [15:0] opa_reg,          opa_next;
    logic [15:0] opb_reg,          opb_next;
    logic [15:0] gap_cnt_reg,      gap_cnt_next;
    logic [7:0]  fpu_cnt_reg,      fpu_cnt_next;
    logic [15:0] result_reg,       result_next;
    logic [4:0]  flags_reg,        flags_next;
    logic        result_valid_reg, result_valid_next;
    logic        err_reg,          err_next;
    logic [1:0]  err_code_reg,     err_code_next;

    logic byte_phase;

    assign byte_phase = (state_reg == OPC)  || (state_reg == A_HI) ||
                        (state_reg == A_LO) || (state_reg == B_HI) ||
                        (state_reg == B_LO);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_reg        <= IDLE;
            opcode_reg       <= 4'd0;
            opa_reg          <= 16'd0;
            opb_reg          <= 16'd0;
            gap_cnt_reg      <= 16'd0;
            fpu_cnt_reg      <= 8'd0;
            result_reg       <= 16'd0;
            flags_reg        <= 5'd0;
            result_valid_reg <= 1'b0;
            err_reg          <= 1'b0;
            err_code_reg     <= ERR_NONE;
        end else begin
            state_reg        <= state_next;
            opcode_reg       <= opcode_next;
            opa_reg          <= opa_next;
            opb_reg          <= opb_next;
            gap_cnt_reg      <= gap_cnt_next;
            fpu_cnt_reg      <= fpu_cnt_next;
            result_reg       <= result_next;
            flags_reg        <= flags_next;
            result_valid_reg <= result_valid_next;
            err_reg          <= err_next;
            err_code_reg     <= err_code_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        opcode_next       = opcode_reg;
        opa_next          = opa_reg;
        opb_next          = opb_reg;
        gap_cnt_next      = gap_cnt_reg;
        fpu_cnt_next      = fpu_cnt_reg;
        result_next       = result_reg;
        flags_next        = flags_reg;
        result_valid_next = 1'b0;
        err_next          = 1'b0;
        err_code_next     = err_code_reg;

        if (byte_phase) begin
            // Timeout has priority: a byte landing in the expiry cycle is dropped.
            if (gap_cnt_reg == BYTE_TIMEOUT) begin
                state_next    = IDLE;
                gap_cnt_next  = 16'd0;
                err_next      = 1'b1;
                err_code_next = ERR_BYTE_TO;
            end else if (rx_valid) begin
                gap_cnt_next = 16'd0;
                case (state_reg)
                    OPC: begin
                        opcode_next = rx_byte[3:0];
                        if (rx_byte >= NUM_OPS) begin
                            state_next    = IDLE;
                            err_next      = 1'b1;
                            err_code_next = ERR_ILL_OP;
                        end else begin
                            state_next = A_HI;
                        end
                    end
                    A_HI: begin
                        opa_next[15:8] = rx_byte;
                        state_next     = A_LO;
                    end
                    A_LO: begin
                        opa_next[7:0] = rx_byte;
                        state_next    = B_HI;
                    end
                    B_HI: begin
                        opb_next[15:8] = rx_byte;
                        state_next     = B_LO;
                    end
                    B_LO: begin
                        opb_next[7:0] = rx_byte;
                        state_next    = ISSUE;
                    end
                    default: state_next = IDLE;
                endcase
            end else begin
                gap_cnt_next = gap_cnt_reg + 16'd1;
            end
        end else begin
            gap_cnt_next = 16'd0;
            case (state_reg)
                IDLE: begin
                    if (rx_valid && (rx_byte == HDR_BYTE)) begin
                        state_next = OPC;
                    end
                end
                ISSUE: begin
                    // Waiting for ready is unbounded; the FPU owns that stall.
                    if (fpu_ready) begin
                        state_next   = WAIT;
                        fpu_cnt_next = 8'd0;
                    end
                end
                WAIT: begin
                    if (fpu_done) begin
                        result_next       = fpu_result;
                        flags_next        = fpu_flags;
                        result_valid_next = 1'b1;
                        err_code_next     = ERR_NONE;
                        state_next        = IDLE;
                    end else if (fpu_cnt_reg == FPU_TIMEOUT) begin
                        err_next      = 1'b1;
                        err_code_next = ERR_FPU_TO;
                        state_next    = IDLE;
                    end else begin
                        fpu_cnt_next = fpu_cnt_reg + 8'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign fpu_valid    = (state_reg == ISSUE);
    assign busy         = (state_reg != IDLE);
    assign fpu_opcode   = opcode_reg;
    assign fpu_opa      = opa_reg;
    assign fpu_opb      = opb_reg;
    assign result_o     = result_reg;
    assign flags_o      = flags_reg;
    assign result_valid = result_valid_reg;
    assign err_o        = err_reg;
    assign err_code     = err_code_reg;

endmodule

// File: doc/fpu_cmd_sequencer.md
Name: fpu_cmd_sequencer

Overview:
- Sits between the UART receiver and the half-precision FPU datapath inside the FPU top.
- Assembles received bytes into a 6-byte command frame: header, opcode, operand A, operand B.
- Issues the command to the FPU over a valid/ready handshake, then waits for completion.
- Latches the 16-bit result and flags for the pad output bus. Guards against inter-byte stalls, FPU hangs and illegal opcodes.

Parameters:
- HDR_BYTE, 8'hA5, frame start marker.
- NUM_OPS, 10, number of legal opcodes; an opcode >= NUM_OPS is illegal.
- BYTE_TIMEOUT, 16'd50000, max clk cycles allowed between bytes of one frame.
- FPU_TIMEOUT, 8'd64, max clk cycles from issue acceptance to fpu_done.

Ports:
- clk  in  1  single clock.
- rst_l  in  1  asynchronous active-low reset.
- rx_byte  in  8  byte from UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid in that cycle.
- fpu_valid  out  1  command valid to FPU.
- fpu_ready  in  1  FPU accepts the command when fpu_valid && fpu_ready.
- fpu_opcode  out  4  opcode, low 4 bits of the opcode byte.
- fpu_opa  out  16  operand A.
- fpu_opb  out  16  operand B.
- fpu_done  in  1  one-cycle completion strobe.
- fpu_result  in  16  result, valid with fpu_done.
- fpu_flags  in  5  exception flags {NV,DZ,OF,UF,NX}, valid with fpu_done.
- result_o  out  16  last completed result (drives FPU_hp_result).
- flags_o  out  5  last completed flags.
- result_valid  out  1  one-cycle pulse when result_o/flags_o update.
- busy  out  1  high in every state except IDLE.
- err_o  out  1  one-cycle pulse on any abort.
- err_code  out  2  cause of last abort: 0 none, 1 byte timeout, 2 illegal opcode, 3 FPU timeout.

Behaviour:
- Reset (rst_l=0, async): state=IDLE. All outputs 0: fpu_valid, fpu_opcode, fpu_opa, fpu_opb, result_o, flags_o, result_valid, busy, err_o, err_code. Counters cleared. Reset mid-frame or mid-execution discards everything. Release is synchronous to clk.
- States: IDLE, OPC, A_HI, A_LO, B_HI, B_LO, ISSUE, WAIT.
- IDLE: on rx_valid with rx_byte==HDR_BYTE go to OPC; other bytes are ignored.
- OPC: on rx_valid, store rx_byte[3:0].
  - If rx_byte >= NUM_OPS (full 8-bit compare): err_code=2, pulse err_o, go to IDLE.
  - Otherwise go to A_HI.
- A_HI/A_LO/B_HI/B_LO: capture operands MSB first on each rx_valid. A header value inside a frame is treated as data.
- Byte timeout:
  - In OPC..B_LO a 16-bit gap counter clears on each rx_valid and increments otherwise.
  - When it reaches BYTE_TIMEOUT: err_code=1, pulse err_o, go to IDLE. A byte arriving in that same cycle is dropped.
- ISSUE: entered the cycle after B_LO is captured.
  - fpu_valid=1 with opcode/opa/opb stable. fpu_valid holds until fpu_ready is sampled high. No timeout applies while waiting for ready.
  - On handshake: fpu_valid drops the next cycle, go to WAIT, FPU counter cleared.
- WAIT: FPU counter increments each cycle.
  - On fpu_done: result_o<=fpu_result, flags_o<=fpu_flags, result_valid=1 for exactly one cycle (the cycle after done), err_code<=0, go to IDLE.
  - If the counter reaches FPU_TIMEOUT with no done: err_code=3, pulse err_o, result_o unchanged, go to IDLE.
  - If fpu_done and timeout coincide, done wins.
  - fpu_done outside WAIT is ignored.
- rx_valid in ISSUE/WAIT: byte dropped. A new frame is only recognised after returning to IDLE.
- err_code holds until the next error or the next successful completion.
- Latency from last byte strobe to fpu_valid: 1 cycle. From fpu_done to result_valid: 1 cycle.

Test Plan:
- Frame A5 00 3C 00 40 00, fpu_ready=1, done 5 cycles later with 16'h4200 -> fpu_opcode=0, opa=3C00, opb=4000; result_o=4200 with a single result_valid pulse; busy returns to 0.
- Same frame with fpu_ready held low 10 cycles -> fpu_valid and operands stable for all 11 cycles, exactly one handshake.
- Frame A5 0F ... -> err_o pulse, err_code=2 after the opcode byte, fpu_valid never asserted, remaining bytes ignored unless one is A5.
- A5 01 then silence for BYTE_TIMEOUT cycles -> err_code=1, state IDLE; a following full frame completes normally and err_code returns to 0.
- Handshake done but no fpu_done for 64 cycles -> err_code=3, result_o keeps the previous value; a late fpu_done is ignored.
- Assert rst_l=0 during WAIT and during A_LO -> all outputs 0 immediately; after release a fresh frame executes correctly.
